// File: rtl/hash_compare_array.sv
// hash_compare_array
// Compares LANES candidate hashes per cycle against a loadable target.
// Stage 1 registers per-segment equality bits; stage 2 reduces them to
// per-lane match flags. A sticky result register keeps the ID of the first
// match, and a saturating counter counts matching batches.
module hash_compare_array #(
    parameter int HASH_W = 128,
    parameter int LANES  = 4,
    parameter int ID_W   = 32,
    parameter int SEG_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    target_load,
    input  logic [HASH_W-1:0]       target_in,
    input  logic                    test_en,
    input  logic [LANES*HASH_W-1:0] test_hash,
    input  logic [LANES-1:0]        test_mask,
    input  logic [ID_W-1:0]         test_id,
    input  logic                    clear_found,
    output logic                    equal_valid,
    output logic [LANES-1:0]        lane_match,
    output logic                    hashes_equal,
    output logic                    found,
    output logic [ID_W-1:0]         found_id,
    output logic [CNT_W-1:0]        match_count
);

    localparam int NSEG   = HASH_W / SEG_W;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [HASH_W-1:0]     target_reg;
    logic                  v1_reg;
    logic [LANES-1:0]      mask1_reg;
    logic [ID_W-1:0]       id1_reg;
    logic [LANES*NSEG-1:0] seg_eq_next;
    logic [LANES*NSEG-1:0] seg_eq_reg;
    logic [LANES-1:0]      lane_hit_next;
    logic [ID_W-1:0]       id2_reg;
    logic [LIDX_W-1:0]     first_idx;
    logic [ID_W-1:0]       capture_id;

    // Per-lane, per-segment partial compares against the live target, and
    // the stage-2 reduction of those registered bits into lane hits.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        for (genvar gs = 0; gs < NSEG; gs++) begin : g_seg
            assign seg_eq_next[gi*NSEG + gs] =
                (test_hash[gi*HASH_W + gs*SEG_W +: SEG_W] ==
                 target_reg[gs*SEG_W +: SEG_W]);
        end
        assign lane_hit_next[gi] = v1_reg & mask1_reg[gi] &
                                   (&seg_eq_reg[gi*NSEG +: NSEG]);
    end

    // Lowest matching lane of the batch currently on the outputs.
    always_comb begin
        first_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_match[i]) begin
                first_idx = LIDX_W'(i);
            end
        end
    end

    // Candidate ID wraps modulo 2^ID_W.
    assign capture_id = id2_reg + ID_W'(first_idx);

    // Target register and stage 1; a load flushes the stage and drops the
    // batch offered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg <= '0;
            v1_reg     <= 1'b0;
            mask1_reg  <= '0;
            id1_reg    <= '0;
            seg_eq_reg <= '0;
        end else if (target_load) begin
            target_reg <= target_in;
            v1_reg     <= 1'b0;
            mask1_reg  <= '0;
        end else begin
            v1_reg     <= test_en;
            mask1_reg  <= test_en ? test_mask : '0;
            id1_reg    <= test_id;
            seg_eq_reg <= seg_eq_next;
        end
    end

    // Stage 2: registered per-lane results, forced to 0 when no batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            equal_valid  <= 1'b0;
            lane_match   <= '0;
            hashes_equal <= 1'b0;
            id2_reg      <= '0;
        end else if (target_load) begin
            equal_valid  <= 1'b0;
            lane_match   <= '0;
            hashes_equal <= 1'b0;
        end else begin
            equal_valid  <= v1_reg;
            lane_match   <= lane_hit_next;
            hashes_equal <= |lane_hit_next;
            id2_reg      <= id1_reg;
        end
    end

    // Sticky first-match capture and saturating batch counter. A match
    // arriving with clear_found restarts the record from that match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found       <= 1'b0;
            found_id    <= '0;
            match_count <= '0;
        end else if (target_load) begin
            found       <= 1'b0;
            found_id    <= '0;
            match_count <= '0;
        end else if (clear_found) begin
            found       <= hashes_equal;
            found_id    <= hashes_equal ? capture_id : '0;
            match_count <= hashes_equal ? CNT_W'(1) : '0;
        end else if (hashes_equal) begin
            if (!found) begin
                found    <= 1'b1;
                found_id <= capture_id;
            end
            if (match_count != {CNT_W{1'b1}}) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule
